time_decoder: RTL and testbench
===============================

# time_decoder

Sequential converter from a seconds-of-day count (0..MAX_COUNT) to six BCD display digits (HH:MM:SS).
- Sits directly downstream of the time counter and upstream of the seven-segment display driver.
- Conversion uses repeated subtraction, one step per clock, under a start/done handshake.
- Results are registered and held until the next completed conversion.

## Interface
Parameters:
- BIT_WIDTH, 17, width of i_Count
- MAX_COUNT, 86399, largest legal count (23:59:59)

Ports:
- i_Clk  in  1  clock
- i_Reset  in  1  reset, asynchronous, active-high
- i_Start  in  1  conversion request, sampled only in IDLE
- i_Count  in  BIT_WIDTH  seconds-of-day value, sampled with i_Start
- o_Busy  out  1  high in every state except IDLE
- o_Done  out  1  one-cycle pulse; digits valid from this cycle
- o_Error  out  1  one-cycle pulse; rejected request (i_Count > MAX_COUNT)
- o_Hours_Tens, o_Hours_Ones  out  4 each  hour BCD digits
- o_Minutes_Tens, o_Minutes_Ones  out  4 each  minute BCD digits
- o_Seconds_Tens, o_Seconds_Ones  out  4 each  second BCD digits
- o_PM  out  1  PM flag; 12-hour build only, otherwise constant 0

## Operation
States and transitions:
- IDLE, on i_Start with i_Count <= MAX_COUNT: latch i_Count into the remainder, clear the hour and minute accumulators, go to HOURS.
- IDLE, on i_Start with i_Count > MAX_COUNT: pulse o_Error, stay in IDLE, leave digits unchanged.
- HOURS: if remainder >= 3600, subtract 3600 and increment hours; otherwise go to MINUTES.
- MINUTES: if remainder >= 60, subtract 60 and increment minutes; otherwise go to SPLIT.
- SPLIT: split hours, minutes and remainder (seconds) into tens/ones, apply the 12-hour mapping if built in, register all digits and o_PM, go to DONE.
- DONE: o_Done = 1 for this cycle, then go to IDLE.

Rules:
- i_Start is ignored outside IDLE; i_Count is not re-sampled during a conversion.
- Arithmetic: remainder is BIT_WIDTH bits; hours accumulator 5 bits (max 23); minutes accumulator 6 bits (max 59). No underflow is possible because every subtraction is guarded by a compare.
- Digit outputs change only on the SPLIT->DONE edge, so the display never shows partial results.
- Reset, at any time including mid-conversion: state IDLE, o_Busy/o_Done/o_Error = 0, all digits 0 (hours 1,2 in the 12-hour build), o_PM = 0. No o_Done for the aborted conversion.

## Timing
- i_Start high in cycle 0 with hours value H and minutes value M: o_Done is high in cycle H+M+4.
  - Minimum latency 4 cycles; maximum 86 cycles (23:59:59).
- o_Busy rises in cycle 1 and falls in cycle H+M+5.
- o_Error pulses in cycle 1.
- Earliest next accepted i_Start: cycle H+M+5.

## Configuration
Macro TIME_DECODE_12H_EN.
- Defined: 12-hour display.
  - H = 0 gives 12 AM; H = 1..11 gives H AM; H = 12 gives 12 PM; H = 13..23 gives H-12 PM.
  - o_PM = 1 for PM.
  - Reset digits read 12:00:00, o_PM = 0.
- Undefined: 24-hour display (00..23), o_PM constant 0, reset digits 00:00:00.
- Latency is identical in both builds.

## Structure
- Shared package time_pkg holds:
  - SECONDS_PER_HOUR = 3600, SECONDS_PER_MINUTE = 60
  - default MAX_COUNT = 86399
  - state encoding: IDLE, HOURS, MINUTES, SPLIT, DONE
- Sub-module bin_to_bcd_2digit: combinational 0..59 to tens/ones conversion, instantiated three times. Its outputs are registered by time_decoder in SPLIT.

## Test plan
- Reset asserted, then released -> digits 00:00:00 (12H build: 12:00:00), o_Busy = 0, o_Done = 0, o_PM = 0.
- i_Count = 0, i_Start in cycle 0 -> o_Done in cycle 4, digits 00:00:00 (12H build: 12:00:00 with o_PM = 0).
- i_Count = 86399 -> o_Done in cycle 86, digits 23:59:59 (12H build: 11:59:59 with o_PM = 1).
- i_Count = 45296 -> o_Done in cycle 50, digits 12:34:56 (12H build: o_PM = 1).
- i_Count = 86400 with i_Start -> o_Error in cycle 1, o_Busy stays 0, digits unchanged from the previous conversion.
- Start i_Count = 3661; in cycle 3 pulse i_Start with i_Count = 7200 -> ignored, o_Done in cycle 6 with 01:01:01. Repeat, asserting i_Reset in cycle 3 -> reset values immediately, no o_Done.

Source files
------------

// File: rtl/time_pkg.sv
// time_pkg: constants and state encoding shared by the time_decoder slice.
//   SECONDS_PER_HOUR / SECONDS_PER_MINUTE : subtraction step sizes
//   DEFAULT_MAX_COUNT                     : largest legal seconds-of-day (23:59:59)
//   state_t                               : conversion FSM states
package time_pkg;

  localparam int SECONDS_PER_HOUR   = 3600;
  localparam int SECONDS_PER_MINUTE = 60;
  localparam int DEFAULT_MAX_COUNT  = 86399;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOURS   = 3'd1,
    MINUTES = 3'd2,
    SPLIT   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/bin_to_bcd_2digit.sv
// bin_to_bcd_2digit: combinational split of a 0..59 value into BCD tens/ones.
// Ports:
//   i_Value  in  6  binary value, 0..59
//   o_Tens   out 4  tens digit
//   o_Ones   out 4  ones digit
module bin_to_bcd_2digit (
  input  logic [5:0] i_Value,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Ones
);

  logic [5:0] w_Rem;

  // Compare chain instead of a divider: only six possible tens values.
  always_comb begin
    o_Tens = 4'd0;
    w_Rem  = i_Value;
    if (i_Value >= 6'd50) begin
      o_Tens = 4'd5;
      w_Rem  = i_Value - 6'd50;
    end else if (i_Value >= 6'd40) begin
      o_Tens = 4'd4;
      w_Rem  = i_Value - 6'd40;
    end else if (i_Value >= 6'd30) begin
      o_Tens = 4'd3;
      w_Rem  = i_Value - 6'd30;
    end else if (i_Value >= 6'd20) begin
      o_Tens = 4'd2;
      w_Rem  = i_Value - 6'd20;
    end else if (i_Value >= 6'd10) begin
      o_Tens = 4'd1;
      w_Rem  = i_Value - 6'd10;
    end
    o_Ones = w_Rem[3:0];
  end

  logic w_Unused;
  assign w_Unused = ^w_Rem[5:4];

endmodule

// File: rtl/time_decoder.sv
// time_decoder: converts a seconds-of-day count into HH:MM:SS BCD digits by
// repeated subtraction (one step per clock) under a start/done handshake.
// Digits are registered and held until the next completed conversion.
// Optional macro TIME_DECODE_12H_EN selects a 12-hour display with o_PM.
// Ports:
//   i_Clk, i_Reset (async, active-high)
//   i_Start, i_Count          conversion request and seconds value (IDLE only)
//   o_Busy                    high whenever not IDLE
//   o_Done                    one-cycle pulse, digits valid from this cycle
//   o_Error                   one-cycle pulse, request with i_Count > MAX_COUNT
//   o_Hours_*, o_Minutes_*, o_Seconds_*  BCD digits
//   o_PM                      PM flag (12-hour build), else 0
module time_decoder
  import time_pkg::*;
#(
  parameter int BIT_WIDTH = 17,
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Start,
  input  logic [BIT_WIDTH-1:0] i_Count,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic                 o_Error,
  output logic [3:0]           o_Hours_Tens,
  output logic [3:0]           o_Hours_Ones,
  output logic [3:0]           o_Minutes_Tens,
  output logic [3:0]           o_Minutes_Ones,
  output logic [3:0]           o_Seconds_Tens,
  output logic [3:0]           o_Seconds_Ones,
  output logic                 o_PM
);

  localparam logic [BIT_WIDTH-1:0] LP_HOUR = BIT_WIDTH'(SECONDS_PER_HOUR);
  localparam logic [BIT_WIDTH-1:0] LP_MIN  = BIT_WIDTH'(SECONDS_PER_MINUTE);
  localparam logic [BIT_WIDTH-1:0] LP_MAX  = BIT_WIDTH'(MAX_COUNT);

`ifdef TIME_DECODE_12H_EN
  localparam logic [3:0] LP_RST_HOURS_TENS = 4'd1;
  localparam logic [3:0] LP_RST_HOURS_ONES = 4'd2;
`else
  localparam logic [3:0] LP_RST_HOURS_TENS = 4'd0;
  localparam logic [3:0] LP_RST_HOURS_ONES = 4'd0;
`endif

  state_t                r_State, w_Next_State;
  logic [BIT_WIDTH-1:0]  r_Remainder;
  logic [4:0]            r_Hours;
  logic [5:0]            r_Minutes;
  logic                  r_Error;
  logic                  r_PM;
  logic [3:0]            r_Hours_Tens, r_Hours_Ones;
  logic [3:0]            r_Minutes_Tens, r_Minutes_Ones;
  logic [3:0]            r_Seconds_Tens, r_Seconds_Ones;

  logic                  w_Count_Bad;
  logic                  w_Hour_Step;
  logic                  w_Min_Step;
  logic [4:0]            w_Hours_Disp;
  logic                  w_PM;

  assign w_Count_Bad = (i_Count > LP_MAX);
  assign w_Hour_Step = (r_Remainder >= LP_HOUR);
  assign w_Min_Step  = (r_Remainder >= LP_MIN);

`ifdef TIME_DECODE_12H_EN
  always_comb begin
    w_Hours_Disp = r_Hours;
    if (r_Hours == 5'd0)
      w_Hours_Disp = 5'd12;
    else if (r_Hours > 5'd12)
      w_Hours_Disp = r_Hours - 5'd12;
    w_PM = (r_Hours >= 5'd12);
  end
`else
  assign w_Hours_Disp = r_Hours;
  assign w_PM         = 1'b0;
`endif

  // Three identical 0..59 splitters: hours, minutes, seconds.
  logic [5:0] w_Bin  [3];
  logic [3:0] w_Tens [3];
  logic [3:0] w_Ones [3];

  // In SPLIT the remainder is below 60, so its low 6 bits are the seconds.
  assign w_Bin[0] = {1'b0, w_Hours_Disp};
  assign w_Bin[1] = r_Minutes;
  assign w_Bin[2] = r_Remainder[5:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bcd
      bin_to_bcd_2digit u_bcd (
        .i_Value (w_Bin[gi]),
        .o_Tens  (w_Tens[gi]),
        .o_Ones  (w_Ones[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)
      r_State <= IDLE;
    else
      r_State <= w_Next_State;
  end

  always_comb begin
    w_Next_State = r_State;
    o_Busy       = 1'b1;
    o_Done       = 1'b0;
    case (r_State)
      IDLE: begin
        o_Busy = 1'b0;
        if (i_Start && !w_Count_Bad)
          w_Next_State = HOURS;
      end
      HOURS:   if (!w_Hour_Step) w_Next_State = MINUTES;
      MINUTES: if (!w_Min_Step)  w_Next_State = SPLIT;
      SPLIT:   w_Next_State = DONE;
      DONE: begin
        o_Done       = 1'b1;
        w_Next_State = IDLE;
      end
      default: w_Next_State = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Remainder    <= '0;
      r_Hours        <= '0;
      r_Minutes      <= '0;
      r_Error        <= 1'b0;
      r_PM           <= 1'b0;
      r_Hours_Tens   <= LP_RST_HOURS_TENS;
      r_Hours_Ones   <= LP_RST_HOURS_ONES;
      r_Minutes_Tens <= '0;
      r_Minutes_Ones <= '0;
      r_Seconds_Tens <= '0;
      r_Seconds_Ones <= '0;
    end else begin
      r_Error <= 1'b0;
      case (r_State)
        IDLE: begin
          if (i_Start) begin
            if (w_Count_Bad) begin
              r_Error <= 1'b1;
            end else begin
              r_Remainder <= i_Count;
              r_Hours     <= '0;
              r_Minutes   <= '0;
            end
          end
        end
        HOURS: begin
          if (w_Hour_Step) begin
            r_Remainder <= r_Remainder - LP_HOUR;
            r_Hours     <= r_Hours + 5'd1;
          end
        end
        MINUTES: begin
          if (w_Min_Step) begin
            r_Remainder <= r_Remainder - LP_MIN;
            r_Minutes   <= r_Minutes + 6'd1;
          end
        end
        SPLIT: begin
          // Only update point for the display outputs.
          r_Hours_Tens   <= w_Tens[0];
          r_Hours_Ones   <= w_Ones[0];
          r_Minutes_Tens <= w_Tens[1];
          r_Minutes_Ones <= w_Ones[1];
          r_Seconds_Tens <= w_Tens[2];
          r_Seconds_Ones <= w_Ones[2];
          r_PM           <= w_PM;
        end
        default: ;
      endcase
    end
  end

  assign o_Error        = r_Error;
  assign o_PM           = r_PM;
  assign o_Hours_Tens   = r_Hours_Tens;
  assign o_Hours_Ones   = r_Hours_Ones;
  assign o_Minutes_Tens = r_Minutes_Tens;
  assign o_Minutes_Ones = r_Minutes_Ones;
  assign o_Seconds_Tens = r_Seconds_Tens;
  assign o_Seconds_Ones = r_Seconds_Ones;

endmodule

// File: tb/tb_time_decoder.sv
// tb_time_decoder: directed self-checking bench for time_decoder.
// Cycle 0 is the cycle in which i_Start is high; outputs are sampled 1 ns
// after each rising edge. Honours TIME_DECODE_12H_EN for expected values.
module tb_time_decoder;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Start = 1'b0;
  logic [16:0] i_Count = '0;
  logic        o_Busy, o_Done, o_Error, o_PM;
  logic [3:0]  o_Hours_Tens, o_Hours_Ones, o_Minutes_Tens, o_Minutes_Ones;
  logic [3:0]  o_Seconds_Tens, o_Seconds_Ones;
  logic [23:0] w_Digits;

  int checks = 0;
  int errors = 0;

`ifdef TIME_DECODE_12H_EN
  localparam logic [23:0] EXP_RESET = 24'h120000;
  localparam logic [23:0] EXP_ZERO  = 24'h120000;
  localparam logic [23:0] EXP_MAX   = 24'h115959;
  localparam logic        EXP_MAX_PM  = 1'b1;
  localparam logic        EXP_NOON_PM = 1'b1;
`else
  localparam logic [23:0] EXP_RESET = 24'h000000;
  localparam logic [23:0] EXP_ZERO  = 24'h000000;
  localparam logic [23:0] EXP_MAX   = 24'h235959;
  localparam logic        EXP_MAX_PM  = 1'b0;
  localparam logic        EXP_NOON_PM = 1'b0;
`endif

  always #5 i_Clk = ~i_Clk;

  assign w_Digits = {o_Hours_Tens, o_Hours_Ones, o_Minutes_Tens,
                     o_Minutes_Ones, o_Seconds_Tens, o_Seconds_Ones};

  time_decoder #(.BIT_WIDTH(17), .MAX_COUNT(86399)) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Start        (i_Start),
    .i_Count        (i_Count),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Error        (o_Error),
    .o_Hours_Tens   (o_Hours_Tens),
    .o_Hours_Ones   (o_Hours_Ones),
    .o_Minutes_Tens (o_Minutes_Tens),
    .o_Minutes_Ones (o_Minutes_Ones),
    .o_Seconds_Tens (o_Seconds_Tens),
    .o_Seconds_Ones (o_Seconds_Ones),
    .o_PM           (o_PM)
  );

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Drives i_Start in cycle 0; returns positioned in cycle 1.
  task automatic start_conv(input logic [16:0] count);
    i_Start = 1'b1;
    i_Count = count;
    step();
    i_Start = 1'b0;
  endtask

  // Advances until o_Done (bounded); cyc is the current cycle on entry.
  task automatic wait_done(inout int cyc);
    while (o_Done !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    step();
    step();
    i_Reset = 1'b0;
    step();
    checks++;
    if (w_Digits !== EXP_RESET || o_Busy !== 1'b0 || o_Done !== 1'b0 || o_PM !== 1'b0 || o_Error !== 1'b0) begin
      errors++;
      $display("FAIL reset: digits=%h busy=%b done=%b pm=%b err=%b, expected digits=%h busy=0 done=0 pm=0 err=0",
               w_Digits, o_Busy, o_Done, o_PM, o_Error, EXP_RESET);
    end
    $display("reset: digits=%h busy=%b", w_Digits, o_Busy);
  endtask

  task automatic test_conv(input string name, input logic [16:0] count,
                           input int exp_cyc, input logic [23:0] exp_digits,
                           input logic exp_pm);
    int cyc;
    start_conv(count);
    cyc = 1;
    checks++;
    if (o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_rise: busy=%b in cycle 1, expected 1", name, o_Busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s_latency: done in cycle %0d, expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (w_Digits !== exp_digits || o_PM !== exp_pm) begin
      errors++;
      $display("FAIL %s_digits: got %h pm=%b, expected %h pm=%b", name, w_Digits, o_PM, exp_digits, exp_pm);
    end
    step();
    checks++;
    if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_fall: busy=%b done=%b in cycle %0d, expected 0 0", name, o_Busy, o_Done, cyc + 1);
    end
    $display("%s: count=%0d done_cycle=%0d digits=%h pm=%b", name, count, cyc, w_Digits, o_PM);
  endtask

  task automatic test_error();
    logic [23:0] prev;
    prev = w_Digits;
    start_conv(17'd86400);
    checks++;
    if (o_Error !== 1'b1 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL error_pulse: err=%b busy=%b in cycle 1, expected err=1 busy=0", o_Error, o_Busy);
    end
    step();
    checks++;
    if (o_Error !== 1'b0 || o_Busy !== 1'b0 || w_Digits !== prev) begin
      errors++;
      $display("FAIL error_after: err=%b busy=%b digits=%h, expected err=0 busy=0 digits=%h",
               o_Error, o_Busy, w_Digits, prev);
    end
    $display("error: count=86400 digits=%h", w_Digits);
  endtask

  task automatic test_ignored_start();
    int cyc;
    start_conv(17'd3661);
    step();                 // cycle 2
    step();                 // cycle 3
    i_Start = 1'b1;
    i_Count = 17'd7200;
    step();                 // cycle 4
    i_Start = 1'b0;
    cyc = 4;
    checks++;
    if (o_Error !== 1'b0) begin
      errors++;
      $display("FAIL ignored_no_error: err=%b, expected 0", o_Error);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 6 || w_Digits !== 24'h010101) begin
      errors++;
      $display("FAIL ignored_start: done cycle %0d digits %h, expected cycle 6 digits 010101", cyc, w_Digits);
    end
    step();
    $display("ignored_start: done_cycle=%0d digits=%h", cyc, w_Digits);
  endtask

  task automatic test_reset_mid();
    int dones;
    start_conv(17'd3661);
    step();                 // cycle 2
    step();                 // cycle 3
    i_Reset = 1'b1;
    #1;
    checks++;
    if (w_Digits !== EXP_RESET || o_Busy !== 1'b0 || o_Done !== 1'b0 || o_PM !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: digits=%h busy=%b done=%b pm=%b, expected %h 0 0 0",
               w_Digits, o_Busy, o_Done, o_PM, EXP_RESET);
    end
    step();
    i_Reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_Done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done: dones=%0d busy=%b, expected 0 0", dones, o_Busy);
    end
    $display("reset_mid: digits=%h dones=%0d", w_Digits, dones);
  endtask

  initial begin
    test_reset();
    test_conv("zero", 17'd0, 4, EXP_ZERO, 1'b0);
    test_conv("max", 17'd86399, 86, EXP_MAX, EXP_MAX_PM);
    test_conv("noon", 17'd45296, 50, 24'h123456, EXP_NOON_PM);
    test_error();
    test_conv("one_am", 17'd3661, 6, 24'h010101, 1'b0);
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
